// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - control-field layout and constants shared by pipeline stage buffers
package pipe_pkg;

  localparam int CTRL_FIELD_W = 16;
  localparam logic [CTRL_FIELD_W-1:0] CTRL_BUBBLE = '0;

  localparam int BIT_IRET       = 0;
  localparam int BIT_REG_DST    = 1;
  localparam int BIT_BRANCH     = 2;
  localparam int BIT_MEM_READ   = 3;
  localparam int BIT_MEM_TO_REG = 4;
  localparam int BIT_MEM_WRITE  = 5;
  localparam int BIT_ALU_SRC    = 6;
  localparam int BIT_REG_WRITE  = 7;
  localparam int BIT_WORD       = 8;
  localparam int BIT_IGNORE_OP2 = 9;
  localparam int BIT_TLB_WRITE  = 10;

  // Field order mirrors the BIT_* indices; iret sits at bit 0 so it can drive the fetch hold.
  typedef struct packed {
    logic [4:0] rsvd;
    logic       tlb_write;
    logic       ignore_op2;
    logic       word;
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       branch;
    logic       reg_dst;
    logic       iret;
  } ctrl_t;

endpackage

// File: rtl/pipe_ring_ctrl.sv
// rtl/pipe_ring_ctrl.sv - ring pointers, occupancy, handshake and flush kill accounting
module pipe_ring_ctrl #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic             push,
  output logic             pop,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] kill_count
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
  localparam int               SUM_W    = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 2;
  localparam logic [SUM_W-1:0] CNT_MAX  = SUM_W'({CNT_W{1'b1}});

  logic             full;
  logic [SUM_W-1:0] killed;
  logic [SUM_W-1:0] kill_sum;

  assign full      = (occupancy == FULL_OCC);
  assign out_valid = (occupancy != '0);

  // A single entry needs the out_ready bypass to stream at full rate; deeper rings stay registered.
  generate
    if (DEPTH == 1) begin : g_bypass
      assign in_ready = !full || out_ready;
    end else begin : g_registered
      assign in_ready = !full;
    end
  endgenerate

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready;

  // The entry popped alongside a flush belongs downstream, so it is not counted as killed.
  assign killed   = SUM_W'(occupancy) - SUM_W'(pop) + SUM_W'(in_valid);
  assign kill_sum = SUM_W'(kill_count) + killed;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      kill_count <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      if (kill_sum > CNT_MAX) begin
        kill_count <= {CNT_W{1'b1}};
      end else begin
        kill_count <= kill_sum[CNT_W-1:0];
      end
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      occupancy <= occupancy + OCC_W'(push) - OCC_W'(pop);
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - inter-stage pipeline buffer with skid storage, flush and fetch hold
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = CTRL_FIELD_W,
  parameter int DATA_W   = 128,
  parameter int DEPTH    = 2,
  parameter int HOLD_BIT = BIT_IRET,
  parameter int CNT_W    = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_exc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_exc,
  output logic                       out_hold,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           kill_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CTRL_W-1:0] ctrl_mem [DEPTH];
  logic [DEPTH-1:0]  exc_mem;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DATA_W-1:0] last_data;

  pipe_ring_ctrl #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_ring (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .push       (push),
    .pop        (pop),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .occupancy  (occupancy),
    .kill_count (kill_count)
  );

  // Killed entries turn into bubbles; the data payload is deliberately left stale.
  always_ff @(posedge clock or posedge reset) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_mem[i] <= '0;
      end
      exc_mem <= '0;
    end else if (push) begin
      ctrl_mem[wr_ptr] <= in_ctrl;
      exc_mem[wr_ptr]  <= in_exc;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr] <= in_data;
    end
    if (pop) begin
      last_data <= data_mem[rd_ptr];
    end
  end

  assign out_ctrl = out_valid ? ctrl_mem[rd_ptr] : '0;
  assign out_exc  = out_valid && exc_mem[rd_ptr];
  assign out_data = out_valid ? data_mem[rd_ptr] : last_data;

  generate
    if (HOLD_BIT >= 0 && HOLD_BIT < CTRL_W) begin : g_hold
      assign out_hold = out_valid && out_ctrl[HOLD_BIT];
    end else begin : g_no_hold
      assign out_hold = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - directed and randomized checks of pipe_stage_buf against a queue model
module tb_pipe_stage_buf;

  localparam int N  = 4;
  localparam int DW = 128;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic          in_exc;
  logic [15:0]   in_ctrl;
  logic [DW-1:0] in_data;

  always #5 clock = ~clock;

  logic          ir [N];
  logic          ov [N];
  logic [15:0]   oc [N];
  logic [DW-1:0] od [N];
  logic          oe [N];
  logic          oh [N];
  logic [1:0]    occ0, occ2, occ3;
  logic [0:0]    occ1;
  logic [15:0]   kc0, kc1, kc2;
  logic [1:0]    kc3;
  int            occ [N];
  int            kc  [N];

  always_comb begin
    occ[0] = int'(occ0);
    occ[1] = int'(occ1);
    occ[2] = int'(occ2);
    occ[3] = int'(occ3);
    kc[0]  = int'(kc0);
    kc[1]  = int'(kc1);
    kc[2]  = int'(kc2);
    kc[3]  = int'(kc3);
  end

  pipe_stage_buf #(.DEPTH(2)) u_d2 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_exc(in_exc), .out_valid(ov[0]), .out_ready(out_ready),
    .out_ctrl(oc[0]), .out_data(od[0]), .out_exc(oe[0]), .out_hold(oh[0]), .occupancy(occ0), .kill_count(kc0));

  pipe_stage_buf #(.DEPTH(1)) u_d1 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_exc(in_exc), .out_valid(ov[1]), .out_ready(out_ready),
    .out_ctrl(oc[1]), .out_data(od[1]), .out_exc(oe[1]), .out_hold(oh[1]), .occupancy(occ1), .kill_count(kc1));

  pipe_stage_buf #(.DEPTH(3)) u_d3 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_exc(in_exc), .out_valid(ov[2]), .out_ready(out_ready),
    .out_ctrl(oc[2]), .out_data(od[2]), .out_exc(oe[2]), .out_hold(oh[2]), .occupancy(occ2), .kill_count(kc2));

  pipe_stage_buf #(.DEPTH(2), .CNT_W(2)) u_c2 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[3]),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_exc(in_exc), .out_valid(ov[3]), .out_ready(out_ready),
    .out_ctrl(oc[3]), .out_data(od[3]), .out_exc(oe[3]), .out_hold(oh[3]), .occupancy(occ3), .kill_count(kc3));

  typedef struct packed {
    logic          e;
    logic [15:0]   c;
    logic [DW-1:0] d;
  } ent_t;

  int            depth [N] = '{2, 1, 3, 2};
  int            cmax  [N] = '{65535, 65535, 65535, 3};
  ent_t          mq    [N][$];
  int            mk    [N];
  logic [DW-1:0] mlast [N];
  bit            mlast_ok [N];
  int            checks = 0;
  int            errors = 0;
  logic [15:0]   c3 [3] = '{16'h0041, 16'h0082, 16'h0104};

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit exp_ready(input int i);
    return (mq[i].size() < depth[i]) || (depth[i] == 1 && out_ready);
  endfunction

  task automatic chk(input string tag, input int i, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [15:0] c, input logic [DW-1:0] d,
                       input bit e, input bit r, input bit f);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    in_exc    = e;
    out_ready = r;
    flush     = f;
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      bit   v;
      ent_t h;
      v = mq[i].size() > 0;
      h = v ? mq[i][0] : '0;
      chk("in_ready", i, ir[i], exp_ready(i));
      chk("out_valid", i, ov[i], v);
      chk("out_ctrl", i, oc[i], h.c);
      chk("out_exc", i, oe[i], h.e);
      chk("out_hold", i, oh[i], v && h.c[0]);
      chk("occupancy", i, occ[i], mq[i].size());
      chk("kill_count", i, kc[i], mk[i]);
      if (v) chk("out_data", i, od[i], h.d);
      else if (mlast_ok[i]) chk("out_data_held", i, od[i], mlast[i]);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < N; i++) begin
      bit   rdy, pop, push;
      int   k;
      ent_t ne;
      if (reset) begin
        mq[i].delete();
        mk[i] = 0;
        continue;
      end
      rdy  = exp_ready(i);
      pop  = mq[i].size() > 0 && out_ready;
      push = in_valid && rdy && !flush;
      if (pop) begin
        mlast[i]    = mq[i][0].d;
        mlast_ok[i] = 1'b1;
      end
      if (flush) begin
        k     = mq[i].size() - int'(pop) + int'(in_valid);
        mk[i] = (mk[i] + k > cmax[i]) ? cmax[i] : mk[i] + k;
        mq[i].delete();
      end else begin
        if (pop) void'(mq[i].pop_front());
        if (push) begin
          ne = {in_exc, in_ctrl, in_data};
          mq[i].push_back(ne);
        end
      end
    end
  endtask

  task automatic sample();
    @(negedge clock);
    check_all();
  endtask

  task automatic advance();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  initial begin
    reset = 1'b1;
    drive(0, '0, '0, 0, 0, 0);
    tick();
    reset = 1'b0;

    // Backpressure on a two-entry buffer: third push refused, head stable.
    for (int k = 0; k < 3; k++) begin
      drive(1, c3[k], rnd(), 0, 0, 0);
      sample();
      chk("t2_in_ready", 0, ir[0], (k < 2));
      advance();
    end
    drive(0, '0, '0, 0, 0, 0);
    sample();
    chk("t2_occ", 0, occ[0], 2);
    chk("t2_head", 0, oc[0], 16'h0041);
    advance();

    // Flush with pop and incoming transfer.
    drive(1, 16'h0208, rnd(), 1, 1, 1);
    tick();
    drive(0, '0, '0, 0, 0, 0);
    sample();
    chk("t4_kill", 0, kc[0], 2);
    chk("t4_occ", 0, occ[0], 0);
    chk("t4_ctrl", 0, oc[0], 0);
    advance();

    // Refill, then assert reset between edges.
    for (int k = 0; k < 2; k++) begin
      drive(1, 16'h0011 + 16'(k), rnd(), k[0], 0, 0);
      tick();
    end
    drive(0, '0, '0, 0, 0, 0);
    sample();
    chk("t1_pre_occ", 0, occ[0], 2);
    #2 reset = 1'b1;
    #1;
    chk("t1_valid", 0, ov[0], 0);
    chk("t1_ctrl", 0, oc[0], 0);
    chk("t1_occ", 0, occ[0], 0);
    chk("t1_kill", 0, kc[0], 0);
    chk("t1_ready", 0, ir[0], 1);
    advance();
    reset = 1'b0;

    // Single-entry buffer streaming at full rate.
    for (int k = 0; k < 8; k++) begin
      drive(1, 16'h0080, DW'(k), 0, 1, 0);
      sample();
      chk("t3_ready", 1, ir[1], 1);
      if (k > 0) chk("t3_data", 1, od[1], DW'(k - 1));
      advance();
    end
    drive(0, '0, '0, 0, 1, 0);
    sample();
    chk("t3_last", 1, od[1], DW'(7));
    advance();

    // Fetch hold follows a stalled iret entry.
    drive(1, 16'h0001, rnd(), 0, 0, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, '0, '0, 0, 0, 0);
      sample();
      chk("t6_hold_stall", 0, oh[0], 1);
      advance();
    end
    drive(0, '0, '0, 0, 1, 0);
    sample();
    chk("t6_hold_pop", 0, oh[0], 1);
    advance();
    sample();
    chk("t6_hold_after", 0, oh[0], 0);
    advance();

    // Kill counter saturation.
    for (int k = 0; k < 5; k++) begin
      drive(1, 16'h0004, rnd(), 0, 0, 1);
      tick();
    end
    drive(0, '0, '0, 0, 0, 0);
    sample();
    chk("sat_kill_c2", 3, kc[3], 3);
    chk("sat_kill_c16", 0, kc[0], 5);
    advance();

    // Randomized traffic with sporadic stalls and flushes.
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom), rnd(), $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, '0, '0, 0, 1, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
